// File: rtl/raptor64_target_pipe_pkg.sv
// Shared definitions for the Raptor64 target-tag pipe: tag format and bypass select codes.
package raptor64_target_pipe_pkg;

    localparam int TAG_W = 9;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [2:0] {
        BYP_RF = 3'd0,
        BYP_X  = 3'd1,
        BYP_M1 = 3'd2,
        BYP_M2 = 3'd3,
        BYP_W  = 3'd4,
        BYP_T  = 3'd5
    } byp_sel_e;

    // A tag names a real target only when the register number is not r0.
    function automatic logic tag_valid(input tag_t tag);
        return tag[4:0] != 5'd0;
    endfunction

endpackage

// File: rtl/raptor64_bypass_sel.sv
// Per-operand bypass select: finds the youngest stage whose valid target tag equals the source tag.
module raptor64_bypass_sel
    import raptor64_target_pipe_pkg::*;
(
    input  logic [8:0] src,
    input  logic [8:0] x_rt,
    input  logic [8:0] m1_rt,
    input  logic [8:0] m2_rt,
    input  logic [8:0] w_rt,
    input  logic [8:0] t_rt,
    input  logic       x_is_load,
    input  logic       m1_is_load,
    output logic [2:0] sel,
    output logic       load_match
);

    logic [8:0] stage_tag [5];
    logic [4:0] hit;

    assign stage_tag[0] = x_rt;
    assign stage_tag[1] = m1_rt;
    assign stage_tag[2] = m2_rt;
    assign stage_tag[3] = w_rt;
    assign stage_tag[4] = t_rt;

    // Full 9-bit compare, so a tag from another context never matches.
    for (genvar gi = 0; gi < 5; gi++) begin : g_hit
        assign hit[gi] = tag_valid(stage_tag[gi]) && (stage_tag[gi] == src);
    end

    always_comb begin
        sel = BYP_RF;
        if (hit[0])      sel = BYP_X;
        else if (hit[1]) sel = BYP_M1;
        else if (hit[2]) sel = BYP_M2;
        else if (hit[3]) sel = BYP_W;
        else if (hit[4]) sel = BYP_T;
    end

    // Raw per-operand load-use match; X and M1 are the only stages whose load data is not yet back.
    assign load_match = (hit[0] && x_is_load) || (hit[1] && m1_is_load);

endmodule

// File: rtl/raptor64_target_pipe.sv
// Carries the X-stage target tag through M1/M2/W/T and derives bypass selects, load-use stall and rfwr.
module raptor64_target_pipe
    import raptor64_target_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advanceM1,
    input  logic       advanceM2,
    input  logic       advanceW,
    input  logic [8:0] xRt,
    input  logic       xIsLoad,
    input  logic [8:0] dRa,
    input  logic [8:0] dRb,
    input  logic [8:0] dRc,
    output logic [8:0] m1Rt,
    output logic [8:0] m2Rt,
    output logic [8:0] wRt,
    output logic [8:0] tRt,
    output logic       rfwr,
    output logic [2:0] bypA,
    output logic [2:0] bypB,
    output logic [2:0] bypC,
    output logic       loadHazard
);

    logic [8:0] stage_reg [3];
    logic [8:0] stage_in  [3];
    logic [8:0] t_rt_reg;
    logic       m1_is_load_reg;
    logic [2:0] adv;
    logic [2:0] succ_adv;

    assign stage_in[0] = xRt;
    assign stage_in[1] = stage_reg[0];
    assign stage_in[2] = stage_reg[1];

    // W has no successor gate, so it bubbles on every cycle it does not load.
    assign adv      = {advanceW, advanceM2, advanceM1};
    assign succ_adv = {1'b1, advanceW, advanceM2};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) stage_reg[i] <= '0;
            t_rt_reg       <= '0;
            m1_is_load_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (adv[i])           stage_reg[i] <= stage_in[i];
                else if (succ_adv[i]) stage_reg[i] <= '0;
            end
            t_rt_reg <= stage_reg[2];
            if (advanceM1)      m1_is_load_reg <= xIsLoad;
            else if (advanceM2) m1_is_load_reg <= 1'b0;
        end
    end

    assign m1Rt = stage_reg[0];
    assign m2Rt = stage_reg[1];
    assign wRt  = stage_reg[2];
    assign tRt  = t_rt_reg;
    assign rfwr = tag_valid(stage_reg[2]);

    logic [8:0]      src_tag [3];
    logic [2:0][2:0] byp_sel;
    logic [2:0]      load_match;

    assign src_tag[0] = dRa;
    assign src_tag[1] = dRb;
    assign src_tag[2] = dRc;

    for (genvar gi = 0; gi < 3; gi++) begin : g_byp
        raptor64_bypass_sel u_sel (
            .src        (src_tag[gi]),
            .x_rt       (xRt),
            .m1_rt      (stage_reg[0]),
            .m2_rt      (stage_reg[1]),
            .w_rt       (stage_reg[2]),
            .t_rt       (t_rt_reg),
            .x_is_load  (xIsLoad),
            .m1_is_load (m1_is_load_reg),
            .sel        (byp_sel[gi]),
            .load_match (load_match[gi])
        );
    end

    assign bypA       = byp_sel[0];
    assign bypB       = byp_sel[1];
    assign bypC       = byp_sel[2];
    assign loadHazard = |load_match;

endmodule

// File: doc/raptor64_target_pipe.md
# raptor64_target_pipe

Carries the destination-register tag produced at the register-read/execute boundary (`xRt`, 9-bit `{AXC,reg}`) down the Raptor64 pipeline through M1, M2, writeback and a tail stage. Compares each tag against the three decode-stage source operands and emits the bypass-mux selects and the load-use stall. It is the consumer of the target-register tag: it decides who reads the result the tag announces and when the register file is written.

## Interface
Parameters: none (widths fixed by the 9-bit tag format).
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- advanceM1  in  1  M1 stage accepts from X
- advanceM2  in  1  M2 stage accepts from M1
- advanceW  in  1  W stage accepts from M2
- xRt  in  9  X-stage target tag; low 5 bits zero = no target
- xIsLoad  in  1  X-stage instruction is a memory load
- dRa, dRb, dRc  in  9 each  decode-stage source tags `{dAXC,reg}`
- m1Rt, m2Rt, wRt, tRt  out  9 each  per-stage target tags
- rfwr  out  1  register file write strobe for `wRt`
- bypA, bypB, bypC  out  3 each  operand source select
- loadHazard  out  1  stall request to decode/register-read

## Operation
- Stage registers, for M1, M2 and W with predecessor P and successor N:
  - advance of the stage: load P's tag.
  - otherwise, advance of N: clear to 9'd0 (bubble).
  - otherwise: hold.
  - W has no successor gate: it clears to 0 on any cycle without advanceW.
- `tRt <= wRt` every clock. This covers the one-cycle register-file write latency.
- Load flag travels with the tag: `m1IsLoad` loads `xIsLoad` under advanceM1 and clears on bubble. Loads in M2 and later have data available and set no flag.
- A tag is valid only if bits [4:0] ≠ 0. r0 is never a match and never written.
- Matching is full 9-bit equality, so a different AXC never matches.
- Select encoding, shared constants:
  - `BYP_RF`=0, `BYP_X`=1, `BYP_M1`=2, `BYP_M2`=3, `BYP_W`=4, `BYP_T`=5.
  - Priority for each operand is youngest first: X > M1 > M2 > W > T > RF.
- `loadHazard` = (valid xRt matches any of dRa/dRb/dRc AND xIsLoad) OR (valid m1Rt matches any source AND m1IsLoad).
- `bypX` is still produced while loadHazard is asserted. The consumer ignores it.
- `rfwr` = advanceW-registered valid W tag, i.e. `wRt[4:0]≠0`.

## Timing
- Reset: m1Rt, m2Rt, wRt, tRt, m1IsLoad = 0. Consequently bypA/B/C = `BYP_RF`, loadHazard = 0, rfwr = 0 in the cycle after rst.
- Tag latency: xRt reaches m1Rt 1 clock after an advanceM1 edge, and wRt after 3 consecutive advances. It sits in tRt exactly 1 clock after leaving W.
- Selects and loadHazard are combinational from the current stage registers and inputs, with no added latency.
- Simultaneous advance and successor-advance: advance wins (load, not bubble).
- A stall with all advances low holds every stage except W, which bubbles, and T, which shifts.
- rst asserted mid-stream clears all stages on that edge, overriding any advance.

## Structure
- `BYP_*` constants go in the shared opcode/define include alongside the opcode defines.
- One sub-module, `raptor64_bypass_sel`, instantiated three times (A, B, C):
  - Inputs: a source tag and the five stage tags.
  - Outputs: the 3-bit select and a raw load-match bit.
- The top level holds the stage registers, load flags, hazard OR and rfwr.

## Test plan
- Reset: drive rst with xRt=9'h025 and all advances high -> after release all tags 0, bypA=0, loadHazard=0.
- Forward chain: xRt=9'h003 (non-load), all advances held high, dRa=9'h003 each cycle -> bypA sequence 1,2,3,4,5,0 as the tag moves X→M1→M2→W→T→gone; rfwr=1 only in the W cycle.
- Load-use: xRt=9'h007, xIsLoad=1, dRb=9'h007 -> loadHazard=1. After advanceM1, loadHazard is still 1 (M1). After advanceM2, loadHazard=0 and bypB=3.
- r0/context: xRt=9'h020 (AXC1, r0), dRa=9'h020 -> bypA=0. xRt=9'h025 with dRa=9'h005 -> bypA=0.
- Priority: m2Rt=9'h004 and xRt=9'h004 simultaneously, dRc=9'h004 -> bypC=1.
- Bubble/hold: advanceM1=0, advanceM2=1 with m1Rt=9'h009 -> next m1Rt=0 and m2Rt=9'h009. All advances 0 -> m1Rt/m2Rt hold, wRt→0, tRt←old wRt.
